// File: rtl/hanoi_pkg.sv
// hanoi_pkg: peg indices, move-count width, FSM encoding and the smallest-disk rotation
package hanoi_pkg;
  localparam logic [1:0] PEG_L = 2'd0;
  localparam logic [1:0] PEG_M = 2'd1;
  localparam logic [1:0] PEG_R = 2'd2;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE, CALC, APPLY, DONE} state_t;
  // odd disk counts rotate 0->2->1->0, even counts 0->1->2->0, so the tower always lands on peg 2
  function automatic logic [1:0] peg_next(input logic [1:0] p, input logic odd_n);
    return odd_n ? (p == PEG_L ? PEG_R : p - 2'd1) : (p == PEG_R ? PEG_L : p + 2'd1);
  endfunction
endpackage

// File: rtl/hanoi_top_disk.sv
// hanoi_top_disk: reports whether a peg is empty and the index of its top (smallest) disk
module hanoi_top_disk #(
  parameter int W = 4
) (
  input  logic [W-1:0] mask,
  output logic         empty,
  output logic [3:0]   idx
);
  assign empty = ~|mask;
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) if (mask[i]) idx = 4'(i);
  end
endmodule

// File: rtl/hanoi_move_engine.sv
// hanoi_move_engine: applies one move of the optimal Tower-of-Hanoi solution per STEP.
// Define HANOI_AUTO_STEP_EN to also self-step every AUTO_DIV cycles.
module hanoi_move_engine
  import hanoi_pkg::*;
#(
  parameter int N_DISKS  = 4,
  parameter int AUTO_DIV = 25000000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               STEP,
  output logic               BUSY,
  output logic               DATA_DONE,
  output logic [N_DISKS-1:0] PEG0,
  output logic [N_DISKS-1:0] PEG1,
  output logic [N_DISKS-1:0] PEG2,
  output logic [1:0]         SRC,
  output logic [1:0]         DST,
  output logic [CNT_W-1:0]   MOVE_CNT,
  output logic               SOLVED
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << N_DISKS) - 1);
  localparam logic ODD = 1'(N_DISKS % 2);
  state_t state, nxt;
  logic [N_DISKS-1:0] peg [3];
  logic [N_DISKS-1:0] bit_m;
  logic empty [3];
  logic [3:0] top [3];
  logic [1:0] small_pos, a, b, s, d;
  logic b_to_a, auto_step;
  for (genvar g = 0; g < 3; g++) begin : g_top
    hanoi_top_disk #(.W(N_DISKS)) u_top (.mask(peg[g]), .empty(empty[g]), .idx(top[g]));
  end
  assign PEG0 = peg[0];
  assign PEG1 = peg[1];
  assign PEG2 = peg[2];
  assign BUSY = state != IDLE;
  assign DATA_DONE = state == DONE;
  assign SOLVED = MOVE_CNT == LAST;
  assign a = small_pos == PEG_L ? PEG_M : PEG_L;
  assign b = small_pos == PEG_R ? PEG_M : PEG_R;
  assign bit_m = N_DISKS'(1) << top[SRC];
  // on odd counts the only legal move not involving disk 0 goes between the other two pegs
  assign b_to_a = empty[a] || (!empty[b] && top[b] < top[a]);
  always_comb begin
    nxt = state == IDLE ? ((STEP || auto_step) && !SOLVED ? CALC : IDLE) :
          state == CALC ? APPLY : state == APPLY ? DONE : IDLE;
    s = !MOVE_CNT[0] ? small_pos : b_to_a ? b : a;
    d = !MOVE_CNT[0] ? peg_next(small_pos, ODD) : b_to_a ? a : b;
  end
  always_ff @(posedge CLK) state <= RST ? IDLE : nxt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      peg[0] <= '1;
      peg[1] <= '0;
      peg[2] <= '0;
      SRC <= PEG_L;
      DST <= PEG_L;
      MOVE_CNT <= '0;
      small_pos <= PEG_L;
    end else if (state == CALC) begin
      SRC <= s;
      DST <= d;
    end else if (state == APPLY) begin
      for (int p = 0; p < 3; p++)
        if (2'(p) == SRC) peg[p] <= peg[p] & ~bit_m;
        else if (2'(p) == DST) peg[p] <= peg[p] | bit_m;
      MOVE_CNT <= MOVE_CNT + CNT_W'(1);
      if (top[SRC] == 4'd0) small_pos <= DST;
    end
  end
`ifdef HANOI_AUTO_STEP_EN
  logic [31:0] div_cnt;
  assign auto_step = !SOLVED && div_cnt == 32'(AUTO_DIV - 1);
  always_ff @(posedge CLK) begin
    if (RST) div_cnt <= '0;
    else if (!SOLVED) div_cnt <= auto_step ? '0 : div_cnt + 32'd1;
  end
`else
  assign auto_step = 1'b0 & (AUTO_DIV != 0);
`endif
endmodule

// File: tb/tb_hanoi_move_engine.sv
// tb_hanoi_move_engine: checks 3- and 4-disk engines against the closed-form optimal move sequence
module tb_hanoi_move_engine;
  logic CLK = 1'b0, RST = 1'b1, STEP = 1'b0;
  always #5 CLK = ~CLK;
  logic busy3, done3, solved3, busy4, done4, solved4;
  logic [2:0] p30, p31, p32;
  logic [3:0] p40, p41, p42;
  logic [1:0] src3, dst3, src4, dst4;
  logic [15:0] cnt3, cnt4;
  hanoi_move_engine #(.N_DISKS(3)) dut3 (.CLK(CLK), .RST(RST), .STEP(STEP), .BUSY(busy3), .DATA_DONE(done3),
    .PEG0(p30), .PEG1(p31), .PEG2(p32), .SRC(src3), .DST(dst3), .MOVE_CNT(cnt3), .SOLVED(solved3));
  hanoi_move_engine #(.N_DISKS(4)) dut4 (.CLK(CLK), .RST(RST), .STEP(STEP), .BUSY(busy4), .DATA_DONE(done4),
    .PEG0(p40), .PEG1(p41), .PEG2(p42), .SRC(src4), .DST(dst4), .MOVE_CNT(cnt4), .SOLVED(solved4));
  logic [3:0] apeg [2][3];
  logic [1:0] asrc [2], adst [2];
  logic [15:0] acnt [2];
  logic adone [2], abusy [2], asolved [2];
  assign apeg[0][0] = {1'b0, p30};
  assign apeg[0][1] = {1'b0, p31};
  assign apeg[0][2] = {1'b0, p32};
  assign apeg[1][0] = p40;
  assign apeg[1][1] = p41;
  assign apeg[1][2] = p42;
  assign asrc[0] = src3;
  assign asrc[1] = src4;
  assign adst[0] = dst3;
  assign adst[1] = dst4;
  assign acnt[0] = cnt3;
  assign acnt[1] = cnt4;
  assign adone[0] = done3;
  assign adone[1] = done4;
  assign abusy[0] = busy3;
  assign abusy[1] = busy4;
  assign asolved[0] = solved3;
  assign asolved[1] = solved4;
  int nd [2] = '{3, 4};
  logic [3:0] mpeg [2][3];
  int mcnt [2];
  logic [1:0] msrc [2], mdst [2];
  int passed = 0, total = 0;
  logic started = 1'b0;
  logic [1:0] saw, mv;

  always @(negedge CLK)
    if (started)
      for (int i = 0; i < 2; i++)
        assert ((apeg[i][0] | apeg[i][1] | apeg[i][2]) == 4'((1 << nd[i]) - 1) && (apeg[i][0] & apeg[i][1]) == 0 &&
                (apeg[i][0] & apeg[i][2]) == 0 && (apeg[i][1] & apeg[i][2]) == 0 && asrc[i] != 2'd3 && adst[i] != 2'd3)
        else $error("FAIL invariant N=%0d pegs %h %h %h src %0d dst %0d", nd[i], apeg[i][0], apeg[i][1], apeg[i][2], asrc[i], adst[i]);

  function automatic logic [32:0] obs(input int i);
    return {apeg[i][0], apeg[i][1], apeg[i][2], asrc[i], adst[i], acnt[i], asolved[i]};
  endfunction
  function automatic logic [32:0] expd(input int i);
    return {mpeg[i][0], mpeg[i][1], mpeg[i][2], msrc[i], mdst[i], 16'(mcnt[i]), mcnt[i] == (1 << nd[i]) - 1};
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 2; i++) begin
      mpeg[i][0] = 4'((1 << nd[i]) - 1);
      mpeg[i][1] = 4'd0;
      mpeg[i][2] = 4'd0;
      mcnt[i] = 0;
      msrc[i] = 2'd0;
      mdst[i] = 2'd0;
    end
  endtask

  // move k: disk = trailing zeros of k, pegs from the bitwise formula (targets peg 2 for odd n; swap 1/2 for even n)
  task automatic model_step(output logic [1:0] moved);
    moved = 2'b00;
    for (int i = 0; i < 2; i++) begin
      int k, s, d, z;
      if (mcnt[i] < (1 << nd[i]) - 1) begin
        k = mcnt[i] + 1;
        s = (k & (k - 1)) % 3;
        d = ((k | (k - 1)) + 1) % 3;
        if (nd[i] % 2 == 0) begin
          s = s == 0 ? 0 : 3 - s;
          d = d == 0 ? 0 : 3 - d;
        end
        z = 0;
        while (((k >> z) & 1) == 0) z++;
        mpeg[i][s][z] = 1'b0;
        mpeg[i][d][z] = 1'b1;
        mcnt[i]++;
        msrc[i] = 2'(s);
        mdst[i] = 2'(d);
        moved[i] = 1'b1;
      end
    end
  endtask

  task automatic apply_reset;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    started = 1'b1;
  endtask

  // one STEP pulse; optionally jitters STEP while busy, which must be ignored
  task automatic do_step(input bit noisy, output logic [1:0] seen);
    seen = 2'b00;
    @(negedge CLK) STEP = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge CLK);
      STEP = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      seen |= {adone[1], adone[0]};
    end
    @(negedge CLK);
    STEP = 1'b0;
    seen |= {adone[1], adone[0]};
  endtask

  task automatic test_reset;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs(i) !== expd(i)) $display("FAIL reset_state N=%0d: got %h want %h", nd[i], obs(i), expd(i));
      else passed++;
      total++;
      if ({adone[i], abusy[i]} !== 2'b00) $display("FAIL reset_flags N=%0d: done/busy got %b want 00", nd[i], {adone[i], abusy[i]});
      else passed++;
    end
  endtask

  task automatic test_latency;
    @(negedge CLK) STEP = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      STEP = 1'b0;
      total++;
      if ({adone[1], adone[0], abusy[1], abusy[0]} !== {j == 2, j == 2, j < 3, j < 3})
        $display("FAIL latency cycle %0d: done/busy got %b want %b", j + 1, {adone[1], adone[0], abusy[1], abusy[0]}, {j == 2, j == 2, j < 3, j < 3});
      else passed++;
    end
    model_step(mv);
    total++;
    if ({src3, dst3, p30, p32, src4, dst4, p41} !== {2'd0, 2'd2, 3'b110, 3'b001, 2'd0, 2'd1, 4'b0001})
      $display("FAIL first_move: got %h want %h", {src3, dst3, p30, p32, src4, dst4, p41}, {2'd0, 2'd2, 3'b110, 3'b001, 2'd0, 2'd1, 4'b0001});
    else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs(i) !== expd(i)) $display("FAIL first_state N=%0d: got %h want %h", nd[i], obs(i), expd(i));
      else passed++;
    end
  endtask

  task automatic test_solve;
    for (int n = 0; n < 16; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      do_step(1'b1, saw);
      model_step(mv);
      total++;
      if (saw !== mv) $display("FAIL solve_done move %0d: pulses got %b want %b", n, saw, mv);
      else passed++;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== expd(i)) $display("FAIL solve_state N=%0d move %0d: got %h want %h", nd[i], n, obs(i), expd(i));
        else passed++;
      end
    end
    total++;
    if ({p32, p42, solved3, solved4, cnt3, cnt4} !== {3'b111, 4'b1111, 1'b1, 1'b1, 16'd7, 16'd15})
      $display("FAIL solved_final: got %h want %h", {p32, p42, solved3, solved4, cnt3, cnt4}, {3'b111, 4'b1111, 1'b1, 1'b1, 16'd7, 16'd15});
    else passed++;
  endtask

  task automatic test_held;
    int n3, n4, bad;
    apply_reset();
    n3 = 0;
    n4 = 0;
    bad = 0;
    @(negedge CLK) STEP = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge CLK);
      n3 += int'(adone[0]);
      n4 += int'(adone[1]);
      if ((adone[0] || adone[1]) && j % 4 != 2) bad++;
    end
    STEP = 1'b0;
    repeat (3) @(negedge CLK);
    repeat (5) model_step(mv);
    total++;
    if ({n3, n4, bad} !== {32'd5, 32'd5, 32'd0}) $display("FAIL held_rate: moves3 %0d moves4 %0d misphased %0d want 5 5 0", n3, n4, bad);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs(i) !== expd(i)) $display("FAIL held_state N=%0d: got %h want %h", nd[i], obs(i), expd(i));
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    int dn;
    dn = 0;
    @(negedge CLK) STEP = 1'b1;
    @(negedge CLK) STEP = 1'b0;
    @(negedge CLK) RST = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      dn += int'(adone[0]) + int'(adone[1]);
    end
    RST = 1'b0;
    model_reset();
    total++;
    if (dn != 0) $display("FAIL reset_mid_done: pulses got %0d want 0", dn);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs(i) !== expd(i)) $display("FAIL reset_mid_state N=%0d: got %h want %h", nd[i], obs(i), expd(i));
      else passed++;
    end
    do_step(1'b0, saw);
    model_step(mv);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs(i) !== expd(i)) $display("FAIL reset_mid_restart N=%0d: got %h want %h", nd[i], obs(i), expd(i));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_solve();
    test_held();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hanoi_move_engine.md
Name: hanoi_move_engine

Overview:
- Upstream stage of the draw dispatcher.
- Holds the Tower-of-Hanoi game state as three peg occupancy masks.
- On each STEP request, computes the next legal move of the optimal iterative solution and applies it to the masks.
- Pulses DATA_DONE for one cycle so the dispatcher can schedule a redraw of the updated pegs.

Parameters:
- N_DISKS, 4, number of disks; legal range 1..15. Disk i is bit i of a mask; disk 0 is the smallest.
- AUTO_DIV, 25000000, clock cycles between automatic steps. Used only when HANOI_AUTO_STEP_EN is defined.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- STEP  in  1  request next move. Level, sampled only in IDLE.
- BUSY  out  1  high in CALC, APPLY, DONE.
- DATA_DONE  out  1  one-cycle pulse; peg masks and MOVE_CNT updated and stable.
- PEG0  out  N_DISKS  occupancy mask of peg 0.
- PEG1  out  N_DISKS  occupancy mask of peg 1.
- PEG2  out  N_DISKS  occupancy mask of peg 2.
- SRC  out  2  source peg of last move.
- DST  out  2  destination peg of last move.
- MOVE_CNT  out  16  moves completed.
- SOLVED  out  1  MOVE_CNT == 2^N_DISKS - 1.

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- Reset values:
  - PEG0 = all ones; PEG1 = 0; PEG2 = 0.
  - SRC = 0, DST = 0, MOVE_CNT = 0.
  - DATA_DONE = 0, BUSY = 0, SOLVED = 0.
  - Internal small_pos = 0; FSM state = IDLE.
- Reset mid-operation: RST overrides every state. Any in-flight move is discarded and no DATA_DONE is emitted.
- Direction of the smallest disk, fixed by the parity of N_DISKS:
  - N_DISKS even: 0->1->2->0.
  - N_DISKS odd: 0->2->1->0.
  - In both cases the finished tower ends on peg 2.
- FSM states: IDLE, CALC, APPLY, DONE.
- IDLE:
  - If STEP=1 and SOLVED=0, go to CALC.
  - STEP while SOLVED=1 is ignored.
  - STEP in any state other than IDLE is ignored; no queueing.
- CALC, register SRC/DST:
  - MOVE_CNT even (odd-numbered move): SRC = small_pos, DST = next peg in the direction sequence.
  - MOVE_CNT odd: let a, b be the two pegs other than small_pos, with a < b.
    - If a is empty, move b -> a.
    - If b is empty, move a -> b.
    - Otherwise the peg whose top disk (lowest set bit) has the smaller index is the source.
- APPLY:
  - Clear the top bit of PEG[SRC] and set the same bit in PEG[DST].
  - MOVE_CNT += 1.
  - If the moved disk is 0, small_pos = DST.
  - SOLVED is recomputed from the new MOVE_CNT.
- DONE: DATA_DONE = 1 for exactly this cycle, then return to IDLE.
- Latency: STEP sampled high at edge t gives DATA_DONE high during cycle t+3. Next STEP is accepted at edge t+4 at the earliest.
- Held STEP: produces one move per 4 cycles until SOLVED.
- Widths: MOVE_CNT is 16 bits; the 2^15 - 1 maximum fits, so there is no wrap. Peg indices arithmetic is mod 3 with 2-bit encoding; value 3 is never produced.
- Invariant, checked by the bench: PEG0 | PEG1 | PEG2 = all ones, and the masks are pairwise disjoint.
- No move ever places a larger disk on a smaller one.

Optional Feature:
- Macro: HANOI_AUTO_STEP_EN.
- Defined:
  - An internal counter counts 0..AUTO_DIV-1 and generates an internal step pulse at terminal count.
  - The internal pulse is ORed with STEP.
  - The counter is cleared by RST and halts while SOLVED=1.
- Undefined: no counter exists; moves occur only on STEP.

Decomposition:
- Shared package hanoi_pkg holds:
  - Peg index constants PEG_L=0, PEG_M=1, PEG_R=2.
  - FSM state encoding.
  - MOVE_CNT width constant (16).
- One sub-module: hanoi_top_disk, a combinational priority encoder with mask in and outputs {empty, index of lowest set bit}. It is instantiated three times.

Test Plan:
- N_DISKS=3, reset → PEG0=111, PEG1=000, PEG2=000, MOVE_CNT=0, SOLVED=0, DATA_DONE=0.
- N_DISKS=3, STEP 1 cycle at edge t → DATA_DONE only in cycle t+3; SRC=0, DST=2; PEG0=110, PEG2=001; MOVE_CNT=1.
- N_DISKS=3, second STEP → SRC=0, DST=1; PEG0=100, PEG1=010.
- N_DISKS=3, 7 steps → PEG2=111, SOLVED=1. An 8th STEP produces no DATA_DONE and leaves MOVE_CNT=7.
- N_DISKS=4, first STEP → SRC=0, DST=1, PEG1=0001. After 15 steps PEG2=1111.
- STEP held high across CALC/APPLY → exactly one move per 4 cycles.
- RST asserted in APPLY → next cycle PEG0=all ones, MOVE_CNT=0, no DATA_DONE.
- HANOI_AUTO_STEP_EN with AUTO_DIV=10 → DATA_DONE every 10 cycles until SOLVED.
- Invariant assertions run on every cycle.
